// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Definitions shared by the RGB PWM transmit path (LED driver) and the receive
// path (pwm_duty_decoder), so both ends agree on the PWM period and on the
// decoder state encoding.
//   pwm_state_t : decoder FSM states
//   pwm_period  : PWM period in clocks for intensity MSB index r (2^(r+1))
// -----------------------------------------------------------------------------
package rgb_pkg;

   typedef enum logic [1:0] {
      WAIT_EDGE = 2'd0,
      MEASURE   = 2'd1,
      STUCK     = 2'd2
   } pwm_state_t;

   function automatic int pwm_period(input int r);
      return 1 << (r + 1);
   endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
// Brings an asynchronous level into the clk domain through a 2-FF synchronizer
// and flags its rising edge. A third flop holds the previous synchronized
// level for the edge compare. Reusable for button-style inputs.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset, clears all three flops
//   i_async  : asynchronous input level
//   o_level  : synchronized level (second synchronizer stage)
//   o_rise   : high for one cycle after the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module pwm_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_level = r_s2;
   assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// pwm_duty_decoder
// Recovers the programmed intensity from a PWM waveform of the RGB driver
// format. Measures the high time and the rising-edge-to-rising-edge period;
// a period of exactly PERIOD clocks yields a decoded duty value, any other
// period is reported as an error. No rising edge for TIMEOUT_MULT*PERIOD
// clocks declares the input stuck and reports 0 or full scale from its level.
// Parameters:
//   R            : intensity MSB index, duty is R+1 bits, PERIOD = 2^(R+1)
//   TIMEOUT_MULT : periods without a rising edge before declaring stuck
//                  (TIMEOUT_MULT*PERIOD must not exceed 2^(R+2), the counter
//                  range)
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset, clears every register
//   pwm_in     : PWM waveform, asynchronous to clk
//   duty_out   : last decoded duty (high-cycle count)
//   duty_valid : one-cycle pulse when duty_out updates
//   period_err : one-cycle pulse when a measured period differs from PERIOD
//   stuck      : high while no rising edge has been seen for the timeout
// -----------------------------------------------------------------------------
module pwm_duty_decoder
   import rgb_pkg::*;
#(
   parameter int R            = 8,
   parameter int TIMEOUT_MULT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pwm_in,
   output logic [R:0] duty_out,
   output logic       duty_valid,
   output logic       period_err,
   output logic       stuck
);

   localparam int CNT_W   = R + 2;
   localparam int PERIOD  = pwm_period(R);
   localparam int TIMEOUT = TIMEOUT_MULT * PERIOD;

   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_PERIOD  = CNT_W'(PERIOD);
   // The counter would reach TIMEOUT on the coming edge when it holds
   // TIMEOUT-1 now; comparing against TIMEOUT-1 keeps the compare inside the
   // counter range even when TIMEOUT equals 2^CNT_W.
   localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);

   // Counters stop at all-ones instead of wrapping, so a long stuck level
   // can never alias back to a plausible period.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + C_ONE;
   endfunction

   logic w_level;
   logic w_rise;

   pwm_state_t       r_state;
   pwm_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_period_cnt;
   logic [CNT_W-1:0] w_period_nxt;
   logic [CNT_W-1:0] r_high_cnt;
   logic [CNT_W-1:0] w_high_nxt;
   logic [CNT_W-1:0] w_period_inc;
   logic [CNT_W-1:0] w_high_inc;
   logic [R:0]       r_duty;
   logic [R:0]       w_duty_nxt;
   logic             r_vld;
   logic             w_vld_nxt;
   logic             r_err;
   logic             w_err_nxt;

   pwm_sync_edge u_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_async (pwm_in),
      .o_level (w_level),
      .o_rise  (w_rise)
   );

   assign w_period_inc = sat_inc(r_period_cnt);
   assign w_high_inc   = w_level ? sat_inc(r_high_cnt) : r_high_cnt;

   always_comb begin
      w_state_nxt  = r_state;
      w_period_nxt = r_period_cnt;
      w_high_nxt   = r_high_cnt;
      w_duty_nxt   = r_duty;
      w_vld_nxt    = 1'b0;
      w_err_nxt    = 1'b0;

      case (r_state)
         WAIT_EDGE: begin
            // No reference edge yet, so nothing is measured.
            w_period_nxt = '0;
            w_high_nxt   = '0;
            if (w_rise) begin
               w_state_nxt  = MEASURE;
               w_period_nxt = C_ONE;
               w_high_nxt   = C_ONE;
            end
         end

         MEASURE: begin
            if (w_rise) begin
               // A rise closes the running period and opens the next one;
               // the rise cycle itself is high, so both counters restart at 1.
               if (r_period_cnt == C_PERIOD) begin
                  w_duty_nxt = r_high_cnt[R:0];
                  w_vld_nxt  = 1'b1;
               end else begin
                  w_err_nxt  = 1'b1;
               end
               w_period_nxt = C_ONE;
               w_high_nxt   = C_ONE;
            end else begin
               w_period_nxt = w_period_inc;
               w_high_nxt   = w_high_inc;
               if (r_period_cnt == C_TO_LAST) begin
                  // Input frozen: report 0 or full scale from its level.
                  w_state_nxt = STUCK;
                  w_duty_nxt  = {(R+1){w_level}};
                  w_vld_nxt   = 1'b1;
               end
            end
         end

         STUCK: begin
            if (w_rise) begin
               // Treated like the first edge after reset: no complete period
               // exists yet, so no result is produced here.
               w_state_nxt  = MEASURE;
               w_period_nxt = C_ONE;
               w_high_nxt   = C_ONE;
            end else begin
               w_period_nxt = w_period_inc;
               w_high_nxt   = w_high_inc;
            end
         end

         default: begin
            w_state_nxt  = WAIT_EDGE;
            w_period_nxt = '0;
            w_high_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= WAIT_EDGE;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         r_duty       <= '0;
         r_vld        <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_period_cnt <= w_period_nxt;
         r_high_cnt   <= w_high_nxt;
         r_duty       <= w_duty_nxt;
         r_vld        <= w_vld_nxt;
         r_err        <= w_err_nxt;
      end
   end

   assign duty_out   = r_duty;
   assign duty_valid = r_vld;
   assign period_err = r_err;
   assign stuck      = (r_state == STUCK);

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_decoder
// Directed bench for pwm_duty_decoder (R=8, PERIOD=512, TIMEOUT_MULT=2).
// pwm_in is driven one clock at a time from a phase counter (high while
// phase < hi, phase wraps at per). Iteration i of a drive call waits for
// clock edge i, samples the outputs, then sets pwm_in for the next edge.
// A rise set at iteration i is seen by the FSM at edge i+3, so its result is
// sampled at iteration i+3; the timeout fires 1023 edges after that.
// -----------------------------------------------------------------------------
module tb_pwm_duty_decoder;

   localparam int R   = 8;
   localparam int PER = 512;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       pwm_in = 1'b0;
   logic [R:0] duty_out;
   logic       duty_valid;
   logic       period_err;
   logic       stuck;

   pwm_duty_decoder #(
      .R            (R),
      .TIMEOUT_MULT (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .duty_out   (duty_out),
      .duty_valid (duty_valid),
      .period_err (period_err),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_err  = 0;
   int phase  = 0;
   int n_both = 0;
   int n_vld, n_perr, n_stuck;
   int first_vld, first_perr, first_stuck, last_stuck;
   int duty_log [8];

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_acc();
      n_vld       = 0;
      n_perr      = 0;
      n_stuck     = 0;
      first_vld   = -1;
      first_perr  = -1;
      first_stuck = -1;
      last_stuck  = -1;
      for (int k = 0; k < 8; k++) duty_log[k] = -1;
   endtask

   task automatic drive(input int ncyc, input int hi, input int per);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         if (duty_valid) begin
            if (n_vld < 8) duty_log[n_vld] = int'(duty_out);
            if (first_vld < 0) first_vld = i;
            n_vld++;
         end
         if (period_err) begin
            if (first_perr < 0) first_perr = i;
            n_perr++;
         end
         if (duty_valid && period_err) n_both++;
         if (stuck) begin
            if (first_stuck < 0) first_stuck = i;
            last_stuck = i;
            n_stuck++;
         end
         pwm_in = (phase < hi);
         phase  = (phase + 1) % per;
      end
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_duty",  int'(duty_out),   0);
      chk("rst_vld",   int'(duty_valid), 0);
      chk("rst_perr",  int'(period_err), 0);
      chk("rst_stuck", int'(stuck),      0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Steady 128/512: first rise silent, then one result per period
      phase = 0;
      clear_acc();
      drive(4*PER, 128, PER);
      chk("s128_nvld",  n_vld,       3);
      chk("s128_first", first_vld,   515);
      chk("s128_duty0", duty_log[0], 128);
      chk("s128_duty2", duty_log[2], 128);
      chk("s128_perr",  n_perr,      0);

      // Step to 300: old period reports 128, next reports 300 directly
      clear_acc();
      drive(4*PER, 300, PER);
      chk("step_nvld",  n_vld,       4);
      chk("step_d0",    duty_log[0], 128);
      chk("step_d1",    duty_log[1], 300);
      chk("step_d3",    duty_log[3], 300);
      chk("step_perr",  n_perr,      0);

      // Held low: stuck with duty 0 and a single result
      clear_acc();
      drive(1100, 0, PER);
      chk("low_first_stuck", first_stuck, 514);
      chk("low_nstuck",      n_stuck,     586);
      chk("low_nvld",        n_vld,       1);
      chk("low_duty",        duty_log[0], 0);
      chk("low_perr",        n_perr,      0);

      // Recovery: stuck drops on the rise, decoding resumes a period later
      phase = 0;
      clear_acc();
      drive(4*PER, 128, PER);
      chk("rec_last_stuck", last_stuck,   2);
      chk("rec_stuck_end",  int'(stuck),  0);
      chk("rec_nvld",       n_vld,        3);
      chk("rec_first",      first_vld,    515);
      chk("rec_duty",       duty_log[0],  128);

      // Period 500: errors only, duty held
      drive(10, 100, 500);
      clear_acc();
      drive(1990, 100, 500);
      chk("p500_nperr",  n_perr,         3);
      chk("p500_first",  first_perr,     493);
      chk("p500_nvld",   n_vld,          0);
      chk("p500_duty",   int'(duty_out), 128);

      // Reset mid-period
      drive(100, 100, 500);
      reset = 1'b0;
      #2;
      chk("mid_rst_duty",  int'(duty_out),   0);
      chk("mid_rst_vld",   int'(duty_valid), 0);
      chk("mid_rst_perr",  int'(period_err), 0);
      chk("mid_rst_stuck", int'(stuck),      0);
      clear_acc();
      drive(5, 0, PER);
      chk("in_rst_pulses", n_vld + n_perr, 0);
      reset = 1'b1;
      phase = 0;
      clear_acc();
      drive(4*PER, 128, PER);
      chk("post_rst_first", first_vld,   515);
      chk("post_rst_nvld",  n_vld,       3);
      chk("post_rst_duty",  duty_log[0], 128);
      chk("post_rst_perr",  n_perr,      0);

      // Loopback-style intensities that toggle every period
      begin
         int vals [3];
         vals[0] = 1;
         vals[1] = 255;
         vals[2] = 511;
         for (int v = 0; v < 3; v++) begin
            clear_acc();
            drive(3*PER, vals[v], PER);
            chk($sformatf("lb%0d_d1", vals[v]), duty_log[1], vals[v]);
            chk($sformatf("lb%0d_d2", vals[v]), duty_log[2], vals[v]);
            chk($sformatf("lb%0d_nvld", vals[v]), n_vld, 3);
            chk($sformatf("lb%0d_perr", vals[v]), n_perr, 0);
         end
      end

      // Intensity 0: never toggles, decoded through the stuck path
      clear_acc();
      drive(1300, 0, PER);
      chk("lb0_first_stuck", first_stuck, 514);
      chk("lb0_nvld",        n_vld,       1);
      chk("lb0_duty",        duty_log[0], 0);

      // Held high: one rise clears stuck, then full scale via the stuck path
      clear_acc();
      drive(1300, PER, PER);
      chk("hi_nstuck", n_stuck,     277);
      chk("hi_first",  first_vld,   1026);
      chk("hi_nvld",   n_vld,       1);
      chk("hi_duty",   duty_log[0], 511);
      chk("hi_perr",   n_perr,      0);

      chk("vld_perr_exclusive", n_both, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
